// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// start/busy/done handshake, result held until the next accepted operation.
module seq_shift_add_multiplier #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_r;
    logic                 done_r;

    logic [2*WIDTH-1:0]   acc_next_s;
    logic                 last_step_s;

    assign last_step_s = (count_r == CNT_LAST);

    // Partial-product accumulation for the current multiplier bit.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM and datapath registers; Product is only written on the last RUN step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mcand_r   <= {(2*WIDTH){1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            count_r   <= CNT_ZERO;
            product_r <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r  <= {{WIDTH{1'b0}}, a};
                        mplier_r <= b;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        count_r  <= CNT_ZERO;
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1'b1;
                    mplier_r <= mplier_r >> 1'b1;
                    count_r  <= count_r + CNT_ONE;
                    if (last_step_s) begin
                        product_r <= acc_next_s;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        state_r   <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign product = product_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
